mdu_iter: RTL and testbench

- Parametrised iterative multiply/divide unit. Implements the RV32M operations MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits in the EX stage beside the single-cycle ALU. The pipeline stalls on o_ready low and consumes the result through a valid/ready handshake.
- Uses a radix-2 shift-add multiplier and a restoring divider. One bit is processed per clock, so latency is fixed and independent of operand values.

---
 rtl/mdu_iter.sv | 173 +++++++++++++++++
 tb/tb_mdu_iter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring divider, one bit per clock.
// Optional MDU_FAST_SPECIAL_EN: divide-by-zero, signed overflow and zero-operand multiplies finish one cycle after accept.
module mdu_iter #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_res_ready,
  output logic [XLEN-1:0] o_mdu_data
);

  // state  | meaning
  // IDLE   | ready for a request, result register holds last value
  // CALC   | one multiply/divide iteration per cycle
  // DONE   | result valid, waiting for consumer
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]       r_state;
  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_b;      // multiplicand (mul) or divisor (div)
  logic [XLEN-1:0]  r_acc;    // product high half (mul) or partial remainder (div)
  logic [XLEN-1:0]  r_lo;     // multiplier/product low half (mul) or dividend/quotient (div)
  logic [XLEN-1:0]  r_a_raw;
  logic             r_neg;
  logic             r_div0;
  logic             r_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_data;

  // Accept-time operand conditioning.
  logic            w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_abs, w_b_abs;
  logic            w_div0, w_ovf;

  assign w_a_sgn = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
  assign w_b_sgn = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
  assign w_a_neg = w_a_sgn & i_op_a[XLEN-1];
  assign w_b_neg = w_b_sgn & i_op_b[XLEN-1];
  assign w_a_abs = w_a_neg ? (~i_op_a + 1'b1) : i_op_a;
  assign w_b_abs = w_b_neg ? (~i_op_b + 1'b1) : i_op_b;
  assign w_div0  = i_op[2] && (i_op_b == '0);
  assign w_ovf   = i_op[2] && !i_op[0] && (i_op_a == MIN_NEG) && (i_op_b == '1);

`ifdef MDU_FAST_SPECIAL_EN
  logic            w_fast;
  logic [XLEN-1:0] w_fast_res;

  assign w_fast = w_div0 || w_ovf || (!i_op[2] && ((i_op_a == '0) || (i_op_b == '0)));

  always_comb begin
    w_fast_res = '0;
    if (i_op[2]) begin
      if (w_div0) w_fast_res = i_op[1] ? i_op_a : '1;
      else        w_fast_res = i_op[1] ? '0 : i_op_a;
    end
  end
`endif

  // Single iteration step.
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_sh;
  logic [XLEN:0]   w_div_tr;
  logic [XLEN-1:0] w_acc_nxt, w_lo_nxt;

  assign w_mul_sum = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_div_sh  = {r_acc, r_lo[XLEN-1]};
  assign w_div_tr  = w_div_sh - {1'b0, r_b};

  always_comb begin
    w_acc_nxt = w_mul_sum[XLEN:1];
    w_lo_nxt  = {w_mul_sum[0], r_lo[XLEN-1:1]};
    if (r_op[2]) begin
      if (!w_div_tr[XLEN]) begin
        w_acc_nxt = w_div_tr[XLEN-1:0];
        w_lo_nxt  = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_div_sh[XLEN-1:0];
        w_lo_nxt  = {r_lo[XLEN-2:0], 1'b0};
      end
    end
  end

  // Final sign correction, special-case overrides and result selection.
  logic [2*XLEN-1:0] w_prod, w_prod_c;
  logic [XLEN-1:0]   w_quo_c, w_rem_c, w_result;

  assign w_prod   = {w_acc_nxt, w_lo_nxt};
  assign w_prod_c = r_neg ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_c  = r_neg ? (~w_lo_nxt + 1'b1) : w_lo_nxt;
  assign w_rem_c  = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;

  always_comb begin
    w_result = w_prod_c[XLEN-1:0];
    case (r_op)
      3'd1, 3'd2, 3'd3: w_result = w_prod_c[2*XLEN-1:XLEN];
      3'd4, 3'd5:       w_result = r_div0 ? '1 : (r_ovf ? r_a_raw : w_quo_c);
      3'd6, 3'd7:       w_result = r_div0 ? r_a_raw : (r_ovf ? '0 : w_rem_c);
      default:          w_result = w_prod_c[XLEN-1:0];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_lo    <= '0;
      r_a_raw <= '0;
      r_neg   <= 1'b0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_op    <= i_op;
            r_acc   <= '0;
            r_b     <= i_op[2] ? w_b_abs : w_a_abs;
            r_lo    <= i_op[2] ? w_a_abs : w_b_abs;
            r_a_raw <= i_op_a;
            // Remainder follows the dividend; everything else follows the sign difference.
            r_neg   <= (i_op[2] && i_op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
            r_div0  <= w_div0;
            r_ovf   <= w_ovf;
            r_cnt   <= CNT_W'(XLEN);
            r_state <= S_CALC;
`ifdef MDU_FAST_SPECIAL_EN
            if (w_fast) begin
              r_data  <= w_fast_res;
              r_state <= S_DONE;
            end
`endif
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_data  <= w_result;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (i_res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready    = (r_state == S_IDLE);
  assign o_valid    = (r_state == S_DONE);
  assign o_mdu_data = r_data;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter (XLEN=32): results, latency, handshake hold, flush and reset behaviour.
module tb_mdu_iter;
  localparam int LAT = 33;
`ifdef MDU_FAST_SPECIAL_EN
  localparam int LAT_SP = 1;
  localparam int LAT_MZ = 1;
`else
  localparam int LAT_SP = 33;
  localparam int LAT_MZ = 33;
`endif

  logic        clk = 1'b0;
  logic        i_reset, i_valid, i_flush, i_res_ready;
  logic [2:0]  i_op;
  logic [31:0] i_op_a, i_op_b;
  logic        o_ready, o_valid;
  logic [31:0] o_mdu_data;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.XLEN(32)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_op_a(i_op_a), .i_op_b(i_op_b), .i_flush(i_flush),
    .o_valid(o_valid), .i_res_ready(i_res_ready), .o_mdu_data(o_mdu_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure edges until o_valid, optionally hold the result, then release it.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int hold, input string tag);
    int lat;
    chk(o_ready, 1'b1, {tag, " ready"});
    i_valid = 1'b1; i_op = op; i_op_a = a; i_op_b = b;
    lat = 0;
    do begin
      tick();
      lat++;
      i_valid = 1'b0; i_op_a = 32'hDEADBEEF; i_op_b = 32'h13572468; i_op = ~op;
    end while (!o_valid && lat < 60);
    chk(lat, exp_lat, {tag, " latency"});
    chk(o_mdu_data, exp, {tag, " data"});
    chk(o_ready, 1'b0, {tag, " busy"});
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({o_valid, o_ready, o_mdu_data}, {1'b1, 1'b0, exp}, {tag, " hold"});
    end
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
    chk({o_valid, o_ready}, 2'b01, {tag, " release"});
  endtask

  initial begin
    int seen;
    i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_res_ready = 1'b0;
    i_op = 3'd0; i_op_a = '0; i_op_b = '0;
    tick(); tick();
    i_reset = 1'b0;
    chk(o_ready, 1'b1, "reset ready");
    chk(o_valid, 1'b0, "reset valid");
    chk(o_mdu_data, 32'h0, "reset data");

    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT, 0, "mul 7x-3");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT, 0, "mulhu max");
    run_op(3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, LAT, 0, "mulhsu -1x2");
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, LAT, 0, "mulh min");
    run_op(3'd1, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, LAT, 0, "mulh -1x5");
    run_op(3'd0, 32'd0,        32'd5,        32'h0,        LAT_MZ, 0, "mul 0x5");
    run_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT, 0, "div -7/2");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT, 0, "rem -7/2");
    run_op(3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT, 0, "div 7/-2");
    run_op(3'd6, 32'd7,        32'hFFFFFFFE, 32'h1,        LAT, 0, "rem 7/-2");
    run_op(3'd5, 32'd100,      32'd7,        32'd14,       LAT, 0, "divu 100/7");
    run_op(3'd7, 32'd100,      32'd7,        32'd2,        LAT, 0, "remu 100/7");
    run_op(3'd5, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, LAT, 0, "divu max/16");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SP, 0, "div ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        LAT_SP, 0, "rem ovf");
    run_op(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, LAT_SP, 0, "divu 5/0");
    run_op(3'd6, 32'd5,        32'd0,        32'd5,        LAT_SP, 0, "rem 5/0");
    run_op(3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, LAT_SP, 0, "div -7/0");
    run_op(3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, LAT_SP, 0, "rem -7/0");
    run_op(3'd0, 32'd3,        32'd5,        32'd15,       LAT, 10, "mul hold");

    // Flush five cycles into a DIVU.
    i_valid = 1'b1; i_op = 3'd5; i_op_a = 32'd100; i_op_b = 32'd7;
    tick();
    i_valid = 1'b0;
    repeat (4) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk({o_valid, o_ready}, 2'b01, "flush calc");
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_valid) seen++;
      if (i < 39) tick();
    end
    chk(seen, 0, "flush no valid");
    chk(o_mdu_data, 32'd15, "flush keeps data");
    run_op(3'd0, 32'd3, 32'd4, 32'd12, LAT, 0, "mul after flush");

    // Flush in IDLE drops a simultaneous request.
    i_valid = 1'b1; i_flush = 1'b1; i_op = 3'd0; i_op_a = 32'd9; i_op_b = 32'd9;
    tick();
    i_valid = 1'b0; i_flush = 1'b0;
    chk({o_valid, o_ready}, 2'b01, "flush idle");
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_valid || !o_ready) seen++;
      if (i < 39) tick();
    end
    chk(seen, 0, "flush idle dropped");

    // Flush wins over res_ready in DONE.
    i_valid = 1'b1; i_op = 3'd7; i_op_a = 32'd50; i_op_b = 32'd8;
    tick();
    i_valid = 1'b0;
    seen = 1;
    while (!o_valid && seen < 60) begin
      tick();
      seen++;
    end
    chk(seen, LAT, "flush done latency");
    chk(o_mdu_data, 32'd2, "flush done data");
    i_flush = 1'b1; i_res_ready = 1'b1;
    tick();
    i_flush = 1'b0; i_res_ready = 1'b0;
    chk({o_valid, o_ready}, 2'b01, "flush done");

    // Reset at cycle 10 of a MUL.
    i_valid = 1'b1; i_op = 3'd0; i_op_a = 32'd6; i_op_b = 32'd6;
    tick();
    i_valid = 1'b0;
    repeat (9) tick();
    chk(o_ready, 1'b0, "mul busy pre-reset");
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk({o_valid, o_ready, o_mdu_data}, {1'b0, 1'b1, 32'h0}, "mid reset");
    run_op(3'd5, 32'd1000, 32'd10, 32'd100, LAT, 0, "divu after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
